// File: rtl/mux_2x1_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_2x1_arbiter_if
// Bundles the two requester channels, the shared output channel and the
// grant/select lines of the 2-to-1 round-robin arbiter.
//   master : producers A/B and the consumer (drive req/data/out_ready,
//            observe grants, select and the output channel)
//   slave  : the arbiter itself
// Signals:
//   req_a/data_a, req_b/data_b : requester inputs
//   out_ready                  : consumer accepts a beat this cycle
//   gnt_a/gnt_b/select         : registered grant and mux-select outputs
//   out_valid/out_data         : combinational output channel
// ---------------------------------------------------------------------------
interface mux_2x1_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             out_ready;
  logic             gnt_a;
  logic             gnt_b;
  logic             select;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, select, out_valid, out_data
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, select, out_valid, out_data
  );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// ---------------------------------------------------------------------------
// mux_2x1_arbiter
// Round-robin arbiter sharing one WIDTH-bit valid/ready output channel
// between requesters A and B. Grants are registered and each grant is
// limited to MAX_BURST beats (1..15) before arbitration is re-run.
// select follows the existing mux convention: 1 routes A, 0 routes B.
// Ports:
//   clock   : rising-edge clock
//   reset_b : asynchronous active-low reset
//   bus     : mux_2x1_arbiter_if.slave (requests, data, grants, output)
// ---------------------------------------------------------------------------
module mux_2x1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                clock,
  input logic                reset_b,
  mux_2x1_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic       r_last_a;   // 1: A was served last, 0: B was served last
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_select;

  logic       w_valid;
  logic       w_beat;
  logic       w_own_req;
  logic       w_other_req;
  logic       w_release;

  // Output channel: a beat is only offered while the owner still requests.
  assign w_valid       = (r_gnt_a & bus.req_a) | (r_gnt_b & bus.req_b);
  assign w_beat        = w_valid & bus.out_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = (r_state == IDLE) ? '0
                       : (r_select ? bus.data_a : bus.data_b);
  assign bus.gnt_a     = r_gnt_a;
  assign bus.gnt_b     = r_gnt_b;
  assign bus.select    = r_select;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned; a missing default here would infer a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_own_req    = 1'b0;
    w_other_req  = 1'b0;
    w_release    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_next_cnt = '0;
        // On a tie the grant goes to whoever was not served last.
        if (bus.req_a && (!bus.req_b || !r_last_a)) begin
          w_next_state = SERV_A;
        end else if (bus.req_b) begin
          w_next_state = SERV_B;
        end
      end

      SERV_A, SERV_B: begin
        w_own_req   = (r_state == SERV_A) ? bus.req_a : bus.req_b;
        w_other_req = (r_state == SERV_A) ? bus.req_b : bus.req_a;
        // Release on the final beat of a burst, or as soon as the owner
        // drops its request (no beat can happen in that cycle).
        w_release   = !w_own_req || (w_beat && (r_cnt == LAST_BEAT));
        if (w_release) begin
          w_next_cnt = '0;
          if (w_other_req) begin
            w_next_state = (r_state == SERV_A) ? SERV_B : SERV_A;
          end else if (!w_own_req) begin
            w_next_state = IDLE;
          end
          // else: burst limit hit with no competitor, start a new burst.
        end else if (w_beat) begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Grants and select are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_a <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_select <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_gnt_a  <= (w_next_state == SERV_A);
      r_gnt_b  <= (w_next_state == SERV_B);
      r_select <= (w_next_state == SERV_A);
      if (w_next_state == SERV_A) begin
        r_last_a <= 1'b1;
      end else if (w_next_state == SERV_B) begin
        r_last_a <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_2x1_arbiter
// Scoreboard bench for mux_2x1_arbiter. The stimulus process drives inputs
// just after each rising edge, advances a behavioural owner/burst model and
// pushes the expected beat into a queue. A monitor on the falling edge
// compares grants/select/valid against the model and pops the queue on
// every beat the DUT presents.
// ---------------------------------------------------------------------------
module tb_mux_2x1_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clock = 1'b0;
  logic reset_b;

  always #5 clock = ~clock;

  mux_2x1_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_2x1_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t sb_q[$];

  // Model: owner 0 = nobody, 1 = A, 2 = B; beats_left counts down a burst.
  int m_owner;
  int m_last;
  int m_left;

  logic             e_gnt_a;
  logic             e_gnt_b;
  logic             e_valid;
  logic [WIDTH-1:0] e_data;
  bit               in_reset = 1'b1;
  bit               mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_owner = 0;
    m_last  = 2;
    m_left  = MAX_BURST;
  endfunction

  // Advance the model across one rising edge using the inputs it sampled.
  function automatic void model_step();
    logic own, oth;
    if (m_owner == 0) begin
      if (bus.req_a && bus.req_b) m_owner = (m_last == 1) ? 2 : 1;
      else if (bus.req_a)         m_owner = 1;
      else if (bus.req_b)         m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner;
        m_left = MAX_BURST;
      end
    end else begin
      own = (m_owner == 1) ? bus.req_a : bus.req_b;
      oth = (m_owner == 1) ? bus.req_b : bus.req_a;
      if (own && bus.out_ready) m_left--;
      if (!own || m_left == 0) begin
        if (oth) begin
          m_owner = 3 - m_owner;
          m_last  = m_owner;
          m_left  = MAX_BURST;
        end else if (own) begin
          m_left = MAX_BURST;
        end else begin
          m_owner = 0;
        end
      end
    end
  endfunction

  // Expected outputs for the cycle just driven; queue the beat if one is due.
  function automatic void model_expect();
    beat_t b;
    e_gnt_a = (m_owner == 1);
    e_gnt_b = (m_owner == 2);
    e_valid = (m_owner == 1 && bus.req_a) || (m_owner == 2 && bus.req_b);
    e_data  = (m_owner == 0) ? '0 : ((m_owner == 1) ? bus.data_a : bus.data_b);
    if (e_valid && bus.out_ready) begin
      b.sel  = (m_owner == 1);
      b.data = e_data;
      sb_q.push_back(b);
    end
  endfunction

  task automatic drive(input logic ra, input logic [WIDTH-1:0] da,
                       input logic rb, input logic [WIDTH-1:0] db,
                       input logic rdy);
    @(posedge clock);
    #1;
    model_step();
    bus.req_a     = ra;
    bus.data_a    = da;
    bus.req_b     = rb;
    bus.data_b    = db;
    bus.out_ready = rdy;
    model_expect();
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt_a"},     bus.gnt_a,     1'b0);
    check({tag, "_gnt_b"},     bus.gnt_b,     1'b0);
    check({tag, "_select"},    bus.select,    1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"},  bus.out_data,  8'h00);
  endtask

  // Short low pulse between edges; outputs must drop with no clock edge.
  task automatic async_reset_pulse();
    #1;
    reset_b  = 1'b0;
    in_reset = 1'b1;
    sb_q.delete();
    model_reset();
    #1;
    check_reset_outputs("mid_rst");
    #3;
    reset_b  = 1'b1;
    in_reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mon_en && !in_reset) begin
      beat_t exp_b;
      check("gnt_a",     bus.gnt_a,     e_gnt_a);
      check("gnt_b",     bus.gnt_b,     e_gnt_b);
      check("select",    bus.select,    e_gnt_a);
      check("out_valid", bus.out_valid, e_valid);
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          check("beat_data", bus.out_data, exp_b.data);
          check("beat_src",  bus.select,   exp_b.sel);
        end
      end else begin
        check("idle_data", bus.out_data, e_data);
      end
    end
  end

  initial begin
    logic a_free, b_free;
    logic [WIDTH-1:0] da, db;

    // Reset with both requesting: nothing may be granted or offered.
    reset_b       = 1'b0;
    in_reset      = 1'b1;
    bus.req_a     = 1'b1;
    bus.data_a    = 8'hA1;
    bus.req_b     = 1'b1;
    bus.data_b    = 8'hB2;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    #6;
    reset_b  = 1'b1;
    in_reset = 1'b0;

    // Contention: A wins the first tie, bursts of MAX_BURST alternate.
    repeat (16) drive(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);

    // Single requester B: bursts restart without dropping the grant.
    repeat (2)  drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (10) drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);

    // Back-pressure in SERV_A after two beats.
    repeat (2) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1);
    repeat (5) drive(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0);
    repeat (6) drive(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1);

    // Early drop: A releases after one beat, then a tie goes to B.
    repeat (2) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (2) drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h11, 1'b0, 8'h00, 1'b1);
    repeat (4) drive(1'b1, 8'h22, 1'b1, 8'h33, 1'b1);

    // Randomised traffic, keeping data stable while a beat is pending.
    for (int i = 0; i < 1500; i++) begin
      a_free = !bus.req_a || (e_valid && bus.out_ready && e_gnt_a);
      b_free = !bus.req_b || (e_valid && bus.out_ready && e_gnt_b);
      da = a_free ? WIDTH'($urandom) : bus.data_a;
      db = b_free ? WIDTH'($urandom) : bus.data_b;
      drive(($urandom_range(0, 9) < 7), da, ($urandom_range(0, 9) < 6), db,
            ($urandom_range(0, 3) != 0));
    end

    // Mid-burst reset in SERV_B with two beats done.
    repeat (3) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    async_reset_pulse();
    repeat (10) drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    repeat (2)  drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    @(negedge clock);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
- Round-robin arbiter that shares a single WIDTH-bit output channel between two requesters, A and B, through a 2-to-1 select path.
- It drives the channel `select` line with the team's existing mux convention: select=1 routes A, select=0 routes B.
- It issues registered grants to the requesters and bounds each grant to a burst of at most MAX_BURST beats, so one requester cannot starve the other.
- It sits between two producer blocks and one consumer that uses a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of each requester and of the output channel.
- MAX_BURST, 4, maximum beats transferred per grant before arbitration is forced. Legal range is 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset_b  input  1  asynchronous active-low reset.
- req_a  input  1  requester A has data; held high while data_a is valid.
- data_a  input  WIDTH  requester A data.
- req_b  input  1  requester B has data.
- data_b  input  WIDTH  requester B data.
- out_ready  input  1  consumer accepts a beat this cycle.
- gnt_a  output  1  A owns the channel (registered).
- gnt_b  output  1  B owns the channel (registered).
- select  output  1  mux select: 1 = A, 0 = B (registered).
- out_valid  output  1  beat offered on the output channel (combinational).
- out_data  output  WIDTH  output channel data (combinational).

Behaviour:
- One clock domain. reset_b is asynchronous and active-low.

Reset (while reset_b=0):
- state=IDLE, gnt_a=0, gnt_b=0, select=0.
- Beat counter cnt=0.
- last_served=B, so A wins the first tie.
- Consequently out_valid=0 and out_data=0 during reset.

States: IDLE, SERV_A, SERV_B.
- gnt_a=1 only in SERV_A; gnt_b=1 only in SERV_B.
- select=1 in SERV_A, 0 otherwise.

Datapath:
- out_data = select ? data_a : data_b, forced to 0 in IDLE.
- out_valid = (gnt_a & req_a) | (gnt_b & req_b).
- Beat = out_valid & out_ready on a rising edge.

IDLE:
- Only req_a high -> SERV_A next edge.
- Only req_b high -> SERV_B next edge.
- Both high -> grant goes to the requester that is not last_served.
- Neither high -> stay in IDLE.
- Grant latency is exactly one cycle from req to gnt.
- On entry to SERV_X: last_served<=X, cnt<=0.

SERV_X, where Y is the other requester:
- If req_X=1 and out_ready=0: stall; hold state and cnt.
- On a beat with cnt<MAX_BURST-1: cnt<=cnt+1, stay in SERV_X.
- Release occurs on a beat with cnt==MAX_BURST-1, or when req_X=0 in any cycle (no beat that cycle).
- On release:
  - If req_Y=1 -> SERV_Y directly (no IDLE bubble), cnt<=0.
  - Else if req_X=1 (burst limit hit, no competitor) -> stay in SERV_X, cnt<=0, new burst.
  - Else -> IDLE.

Other rules:
- Requesters must not change data_X while req_X=1 and no beat has occurred. The arbiter does not check this.
- Arbitration decisions use the req values sampled on the same edge as the beat.
- Reset asserted mid-burst returns to the reset values immediately and asynchronously. The in-flight beat is dropped and the counter is cleared.
- cnt is 4 bits wide. It never exceeds MAX_BURST-1.
- MAX_BURST=1 gives strict per-beat alternation when both requesters are active.

Test Plan:
- Reset: reset_b=0 with req_a=req_b=1 -> gnt_a=gnt_b=0, select=0, out_valid=0, out_data=0. After release, gnt_a=1 and select=1 one cycle later.
- Single requester: req_b=1, data_b=8'h5A, out_ready=1, req_a=0 for 10 cycles -> gnt_b=1, select=0, out_data=8'h5A every cycle. Bursts restart every 4 beats with gnt_b never dropping.
- Contention, MAX_BURST=4: req_a=req_b=1, out_ready=1 -> A gets beats 1-4, then B gets beats 5-8, then A again. Grant switches with no idle cycle, and gnt_a/gnt_b are never both 1.
- Back-pressure: in SERV_A after 2 beats, hold out_ready=0 for 5 cycles -> out_valid=1, state and cnt held. After out_ready returns, exactly 2 more A beats occur before the switch to B.
- Early drop: in SERV_A, req_a falls after 1 beat with req_b=0 -> IDLE next edge, out_valid=0. Then req_a=req_b=1 together -> B is granted, since A was last served.
- Mid-burst reset: pulse reset_b low for half a cycle during SERV_B with cnt=2 -> outputs drop immediately, no clock needed. Then with both requesting, A is granted first and receives a full 4-beat burst.
